// File: rtl/crc_code_encoder.sv
// Bit-serial CRC-4 encoder (G(x) = x^4 + x + 1) producing a 12-bit codeword {data, crc}.
// Latency: 13 clocks from the accepting start edge to encoded_data/done; one word per 14 clocks.
// Backpressure: none queued; start is accepted only while busy=0, otherwise it is ignored.
//
// Ports:
//   clk, rst       - rising-edge clock, synchronous active-high reset
//   data_in, start - word to encode and its request strobe (sampled only when idle)
//   encoded_data   - registered codeword, held until the next completion
//   busy           - high while an encode is in progress
//   done           - one-cycle pulse when encoded_data updates
//   encoded_valid  - sticky flag: at least one encode has completed since reset
module crc_code_encoder (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        start,
    output logic [11:0] encoded_data,
    output logic        busy,
    output logic        done,
    output logic        encoded_valid
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [7:0]  data_reg_q, data_reg_d;
    logic [11:0] shift_reg_q, shift_reg_d;
    logic [3:0]  lfsr_q, lfsr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [11:0] encoded_data_q, encoded_data_d;
    logic        done_q, done_d;
    logic        encoded_valid_q, encoded_valid_d;
    logic        in_bit;

    assign in_bit = shift_reg_q[11];

    always_comb begin
        state_d         = state_q;
        data_reg_d      = data_reg_q;
        shift_reg_d     = shift_reg_q;
        lfsr_d          = lfsr_q;
        cnt_d           = cnt_q;
        encoded_data_d  = encoded_data_q;
        done_d          = 1'b0;
        encoded_valid_d = encoded_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    data_reg_d  = data_in;
                    // Four trailing zeros make the final remainder M(x)*x^4 mod G(x).
                    shift_reg_d = {data_in, 4'b0000};
                    lfsr_d      = 4'h0;
                    cnt_d       = 4'd0;
                    state_d     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Galois LFSR step: feedback lfsr[3] taps x^1 and x^0 of G(x).
                lfsr_d      = {lfsr_q[2:1], lfsr_q[3] ^ lfsr_q[0], lfsr_q[3] ^ in_bit};
                shift_reg_d = {shift_reg_q[10:0], 1'b0};
                cnt_d       = cnt_q + 4'd1;
                if (cnt_q == 4'd11) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                encoded_data_d  = {data_reg_q, lfsr_q};
                done_d          = 1'b1;
                encoded_valid_d = 1'b1;
                state_d         = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            data_reg_q      <= 8'h00;
            shift_reg_q     <= 12'h000;
            lfsr_q          <= 4'h0;
            cnt_q           <= 4'd0;
            encoded_data_q  <= 12'h000;
            done_q          <= 1'b0;
            encoded_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            data_reg_q      <= data_reg_d;
            shift_reg_q     <= shift_reg_d;
            lfsr_q          <= lfsr_d;
            cnt_q           <= cnt_d;
            encoded_data_q  <= encoded_data_d;
            done_q          <= done_d;
            encoded_valid_q <= encoded_valid_d;
        end
    end

    assign encoded_data  = encoded_data_q;
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign encoded_valid = encoded_valid_q;

endmodule

// File: doc/crc_code_encoder.md
Name: crc_code_encoder

Overview:
Serial CRC-4 encoder feeding the CRC decoder stage of the memory-protection path.
Accepts an 8-bit data word on a start strobe and computes a 4-bit CRC bit-serially with polynomial x^4 + x + 1.
Shifts the 8 data bits MSB-first, then 4 zero bits, so the remainder equals M(x)·x^4 mod G(x).
Emits a 12-bit codeword {data[7:0], crc[3:0]}; the downstream decoder's LFSR reaches zero on an uncorrupted codeword.

Parameters:
None. Data width 8, CRC width 4 and polynomial x^4 + x + 1 are fixed and must match the decoder.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
data_in  input  8  word to encode, sampled only on an accepted start
start  input  1  request to encode; accepted only when busy=0
encoded_data  output  12  registered codeword {data, crc}; held until next completion
busy  output  1  high while an encode is in progress (state != IDLE)
done  output  1  one-cycle pulse when encoded_data updates
encoded_valid  output  1  level; high once any encode has completed since reset

Behaviour:
- One clock domain; reset is synchronous and active-high. Ports are named clk and rst.
- Reset values:
  - encoded_data = 12'h000; busy = 0; done = 0; encoded_valid = 0.
  - State = IDLE; internal data_reg, shift_reg, lfsr and bit counter are all 0.
  - Reset asserted mid-encode aborts the encode: no done pulse, encoded_data returns to 0.
- State machine IDLE -> SHIFT -> DONE -> IDLE:
  - IDLE:
    - If start=1 at edge N: data_reg <= data_in; shift_reg <= {data_in, 4'b0000}; lfsr <= 0; cnt <= 0; state <= SHIFT.
    - Otherwise hold.
  - SHIFT, each edge:
    - in_bit = shift_reg[11].
    - lfsr <= {lfsr[2:1], lfsr[3]^lfsr[0], lfsr[3]^in_bit}.
    - shift_reg <= shift_reg << 1; cnt <= cnt + 1.
    - Exactly 12 shift edges (N+1..N+12). On the edge where cnt==11, state <= DONE.
  - DONE, edge N+13:
    - encoded_data <= {data_reg, lfsr}; done <= 1; encoded_valid <= 1; state <= IDLE.
- done is high only in the cycle following edge N+13 and is cleared on the next edge.
- busy = (state != IDLE), combinational from the state register:
  - high in the cycles following edges N..N+12;
  - low in the cycle following edge N+13, the same cycle in which done is high.
- Latency from the accepting edge to encoded_data update is 13 clocks; throughput is one word per 14 clocks.
- Start while busy=1 is ignored: no queuing, and data_in is not sampled.
- Start high in the same cycle as done is accepted normally, since the state is IDLE.
- Start held high continuously produces back-to-back encodes, each on the first IDLE edge.
- data_in changes during SHIFT/DONE have no effect on the word in progress.
- encoded_data and encoded_valid remain stable between completions.

Test Plan:
- Reset, then start with data_in=8'h01 -> after 13 clocks done pulses once; encoded_data=12'h013; busy low; encoded_valid=1.
- Encode 8'h00, 8'h80, 8'hFF, 8'hA5 in sequence -> encoded_data 12'h000, 12'h80E, 12'hFF4, 12'hA5B. Each codeword, fed to the decoder and shifted 12 times, gives data_valid=1 and error_detected=0.
- Start with 8'h80, then pulse start with 8'h55 at cycles 3 and 10 of the encode -> both ignored; result 12'h80E; exactly one done pulse; busy high 13 cycles.
- Start held high continuously with data_in=8'hA5 -> done pulses every 14 cycles; encoded_data stays 12'hA5B.
- Assert rst at cycle 6 of an encode of 8'hFF -> next cycle busy=0, encoded_data=0, encoded_valid=0, no done. A fresh start of 8'h01 then yields 12'h013.
- Encode 8'hA5 and flip bit 5 of the codeword before the decoder -> decoder error_detected=1. Confirms the encoder output is a true CRC codeword.
